input_controller: RTL and testbench

Router input-side controller. It pops 11-bit words from a show-ahead FIFO and forwards each word to one of two output ports, selected by the word's MSB. It sits between a router ingress FIFO and two downstream output arbiters. It uses a req/ready handshake per output and sustains up to one word per cycle.

---
 rtl/input_controller_pkg.sv | 18 +
 rtl/input_controller.sv | 77 +++++++
 tb/tb_input_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/input_controller_pkg.sv
// Shared router definitions: default word width, route-select bit and the
// holding-stage state encoding used by the input controller.
package input_controller_pkg;

  localparam int WIDTH_DEFAULT     = 11;
  localparam int ROUTE_BIT_DEFAULT = WIDTH_DEFAULT - 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Port index for a word: its top bit selects port 1.
  function automatic logic route_of(input logic [WIDTH_DEFAULT-1:0] word);
    return word[ROUTE_BIT_DEFAULT];
  endfunction

endpackage

// File: rtl/input_controller.sv
// Router input controller: pops words from a show-ahead FIFO into a one-entry
// holding register and offers each to port 0 or port 1 by its top bit.
module input_controller
  import input_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             almost_empty,
  input  logic [WIDTH-1:0] data_in,
  output logic             read,
  input  logic             ready_0,
  input  logic             ready_1,
  output logic             req_0,
  output logic             req_1,
  output logic [WIDTH-1:0] data_out
);

  localparam int ROUTE_BIT = WIDTH - 1;

  // Handshake: a word moves to port p on a rising edge where req_p and ready_p
  // are both high; req_p never depends on ready_p, and a FULL word keeps req_p
  // and data_out stable until that edge. The FIFO head is consumed on any edge
  // where read is high, which may coincide with a transfer for 1 word/cycle.

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             w_dest;
  logic             w_transfer;
  logic             w_read;
  logic             w_req_0;
  logic             w_req_1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_read) r_data <= data_in;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_0      = 1'b0;
    w_req_1      = 1'b0;
    w_transfer   = 1'b0;
    w_read       = 1'b0;
    w_dest       = r_data[ROUTE_BIT];
    case (r_state)
      ST_EMPTY: begin
        w_read = ~almost_empty;
        if (w_read) w_state_next = ST_FULL;
      end
      ST_FULL: begin
        w_req_0    = ~w_dest;
        w_req_1    = w_dest;
        w_transfer = (w_req_0 & ready_0) | (w_req_1 & ready_1);
        // A refill in the same cycle as a transfer keeps the stage FULL.
        w_read     = ~almost_empty & w_transfer;
        if (w_transfer && !w_read) w_state_next = ST_EMPTY;
      end
      default: w_state_next = ST_EMPTY;
    endcase
    // The pop strobe must stay low for the whole time reset is held.
    w_read = w_read & reset_n;
  end

  assign read     = w_read;
  assign req_0    = w_req_0;
  assign req_1    = w_req_1;
  assign data_out = r_data;

endmodule

// File: tb/tb_input_controller.sv
// Self-checking bench for input_controller: directed and random stimulus
// against a queue-based FIFO/holding-stage reference model.
module tb_input_controller;
  import input_controller_pkg::*;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         almost_empty;
  logic [W-1:0] data_in;
  logic         read;
  logic         ready_0;
  logic         ready_1;
  logic         req_0;
  logic         req_1;
  logic [W-1:0] data_out;

  input_controller #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .almost_empty (almost_empty),
    .data_in      (data_in),
    .read         (read),
    .ready_0      (ready_0),
    .ready_1      (ready_1),
    .req_0        (req_0),
    .req_1        (req_1),
    .data_out     (data_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] fifo_q[$];   // words still in the upstream FIFO
  logic [W-1:0] exp_q[$];    // popped words awaiting delivery, in order
  logic         stall;       // forces almost_empty high
  logic         m_valid;     // a word is being held
  logic [W-1:0] m_data;      // the held word (0 after reset)
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input string field,
                       input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
    end
  endtask

  task automatic drive_head();
    almost_empty = stall || (fifo_q.size() == 0);
    data_in      = (fifo_q.size() != 0) ? fifo_q[0] : W'($urandom);
  endtask

  // One clock: called at a negedge, checks outputs, advances the model at the
  // posedge, returns at the next negedge.
  task automatic step(input string tag);
    logic exp_xfer;
    logic exp_read;
    logic [W-1:0] word;
    drive_head();
    #1;
    exp_xfer = m_valid && (m_data[W-1] ? ready_1 : ready_0);
    exp_read = reset_n && !almost_empty && (!m_valid || exp_xfer);
    check(tag, "read",     W'(read),  W'(exp_read));
    check(tag, "req_0",    W'(req_0), W'(m_valid && !m_data[W-1]));
    check(tag, "req_1",    W'(req_1), W'(m_valid &&  m_data[W-1]));
    check(tag, "data_out", data_out,  m_data);
    if (exp_xfer) begin
      if (exp_q.size() == 0) check(tag, "sb_empty", W'(1), W'(0));
      else check(tag, "delivered", data_out, exp_q.pop_front());
    end
    @(posedge clk);
    if (reset_n) begin
      if (exp_read) begin
        word = fifo_q.pop_front();
        exp_q.push_back(word);
        m_data  = word;
        m_valid = 1'b1;
      end else if (exp_xfer) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic push_word(input logic dest);
    fifo_q.push_back({dest, (W-1)'($urandom)});
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_data  = '0;
    exp_q.delete();
    check(tag, "read",     W'(read),  W'(0));
    check(tag, "req_0",    W'(req_0), W'(0));
    check(tag, "req_1",    W'(req_1), W'(0));
    check(tag, "data_out", data_out,  W'(0));
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    reset_n = 1'b0;
    stall   = 1'b0;
    ready_0 = 1'b0;
    ready_1 = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    fifo_q.push_back(11'h3FD);
    drive_head();
    @(negedge clk);

    // Reset with a non-empty FIFO: nothing popped, outputs zero.
    repeat (2) step("reset");
    reset_n = 1'b1;

    // First word: held off by almost_empty, then popped once and held.
    stall = 1'b1;
    step("stall_empty");
    stall = 1'b0;
    step("first_pop");
    fifo_q.push_back(11'h3FE);
    fifo_q.push_back(11'h3FF);
    repeat (8) push_word(1'b0);
    repeat (2) step("hold_p0");

    // Streaming to port 0 at one word per cycle.
    ready_0 = 1'b1;
    repeat (4) step("stream_p0");

    // FIFO runs dry for two cycles, then resumes.
    stall = 1'b1;
    repeat (2) step("dry_p0");
    stall = 1'b0;
    repeat (2) step("resume_p0");

    // Port-1 word stalls on ready_1 while port 0 is ready.
    fifo_q.delete();
    push_word(1'b1);
    push_word(1'b0);
    push_word(1'b1);
    k = 0;
    while (!(m_valid && m_data[W-1]) && k < 20) begin
      step("seek_p1");
      k++;
    end
    check("seek_p1", "reached", W'(m_valid && m_data[W-1]), W'(1));
    step("stall_p1");
    if (fifo_q.size() != 0) fifo_q[0] = fifo_q[0] ^ 11'h400;
    repeat (2) step("stall_p1_flip");
    ready_1 = 1'b1;
    repeat (4) step("release_p1");

    // Alternating destinations with both ports ready: no bubbles.
    for (int i = 0; i < 12; i++) push_word(i[0]);
    repeat (14) step("alternate");

    // Random traffic: random words, readies and FIFO starvation.
    repeat (400) begin
      if ($urandom_range(0, 3) != 0 && fifo_q.size() < 8) push_word(1'($urandom));
      stall   = ($urandom_range(0, 4) == 0);
      ready_0 = 1'($urandom);
      ready_1 = 1'($urandom);
      step("random");
    end

    // Reset in the middle of a stream: held word dropped, no pop during reset.
    stall   = 1'b0;
    ready_0 = 1'b1;
    ready_1 = 1'b1;
    repeat (6) push_word(1'($urandom));
    repeat (2) step("pre_reset");
    async_reset("mid_reset");
    repeat (2) step("in_reset");
    reset_n = 1'b1;
    repeat (6) step("post_reset");

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
